// File: rtl/lnvd_adc_channel_monitor_if.sv
// Sample bus from the ADC wrapper plus the display outputs of the channel monitor.
// The master side is the ADC/switch environment; the slave side is the monitor.
interface lnvd_adc_channel_monitor_if #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 12,
    parameter int NUM_DIG = 3,
    parameter int SEL_W   = 3
);
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic                     sample_valid;
    logic [SEL_W-1:0]         ch_sel;
    logic [1:0]               mode;
    logic                     clr;
    logic [NUM_DIG*8-1:0]     hex_out;
    logic [DATA_W-1:0]        disp_value;
    logic                     stat_valid;

    modport master (
        output data_in, sample_valid, ch_sel, mode, clr,
        input  hex_out, disp_value, stat_valid
    );

    modport slave (
        input  data_in, sample_valid, ch_sel, mode, clr,
        output hex_out, disp_value, stat_valid
    );
endinterface

// File: rtl/lnvd_adc_channel_monitor.sv
// Multi-channel ADC viewer: live / boxcar average / min hold / max hold of one
// switch-selected channel, shown in hex on active-low 7-segment digits at a divided refresh rate.
module lnvd_adc_channel_monitor #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 12,
    parameter int NUM_DIG     = 3,
    parameter int SEL_W       = 3,
    parameter int AVG_LOG2    = 4,
    parameter int REFRESH_DIV = 5000000
) (
    input logic                     clk,
    input logic                     rst,
    lnvd_adc_channel_monitor_if.slave bus
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [AVG_LOG2-1:0] CNT_FULL = {AVG_LOG2{1'b1}};

    logic [SEL_W-1:0]     ch_sel_r;
    logic [1:0]           mode_r;
    logic [DATA_W-1:0]    live_r;
    logic [ACC_W-1:0]     acc_r;
    logic [AVG_LOG2-1:0]  cnt_r;
    logic [DATA_W-1:0]    avg_r;
    logic [DATA_W-1:0]    min_r;
    logic [DATA_W-1:0]    max_r;
    logic                 have_r;
    logic                 stat_valid_r;
    logic [REF_W-1:0]     ref_cnt_r;
    logic [DATA_W-1:0]    disp_r;
    logic [NUM_DIG*8-1:0] hex_r;

    logic [DATA_W-1:0]    sample_s;
    logic                 in_range_s;
    logic                 restart_s;
    logic                 valid_s;
    logic                 stat_set_s;
    logic                 tick_s;
    logic [ACC_W-1:0]     acc_sum_s;
    logic [DATA_W-1:0]    shown_s;
    logic [NUM_DIG*4-1:0] padded_s;
    logic [NUM_DIG*8-1:0] hex_s;

    function automatic logic [7:0] seg7(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Channel selection and restart detection
    always_comb begin
        sample_s   = '0;
        in_range_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ch_sel == SEL_W'(k)) begin
                sample_s   = bus.data_in[k*DATA_W +: DATA_W];
                in_range_s = 1'b1;
            end else begin
                sample_s   = sample_s;
                in_range_s = in_range_s;
            end
        end
        restart_s  = bus.clr | (bus.ch_sel != ch_sel_r) | (bus.mode != mode_r);
        valid_s    = bus.sample_valid & in_range_s;
        acc_sum_s  = acc_r + {{AVG_LOG2{1'b0}}, sample_s};
        // Average mode only reports once a full block has completed
        stat_set_s = (bus.mode == 2'd1) ? (cnt_r == CNT_FULL) : 1'b1;
        tick_s     = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
    end

    // Display value selection and 7-segment encoding
    always_comb begin
        case (bus.mode)
            2'd0:    shown_s = live_r;
            2'd1:    shown_s = avg_r;
            2'd2:    shown_s = min_r;
            2'd3:    shown_s = max_r;
            default: shown_s = live_r;
        endcase
        padded_s = '0;
        padded_s[DATA_W-1:0] = shown_s;
        hex_s = '1;
        for (int d = 0; d < NUM_DIG; d++) begin
            if (in_range_s) begin
                hex_s[d*8 +: 8] = seg7(padded_s[d*4 +: 4]);
            end else begin
                hex_s[d*8 +: 8] = 8'hBF;
            end
        end
        if (in_range_s) begin
            hex_s[7] = stat_valid_r;
        end else begin
            hex_s[7] = 1'b1;
        end
    end

    // Registered copies of the switch settings
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_sel_r <= '0;
            mode_r   <= 2'd0;
        end else begin
            ch_sel_r <= bus.ch_sel;
            mode_r   <= bus.mode;
        end
    end

    // Live sample capture, unaffected by restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            live_r <= '0;
        end else if (valid_s) begin
            live_r <= sample_s;
        end
    end

    // Statistics: boxcar accumulator, min/max hold and validity flag
    always_ff @(posedge clk) begin
        if (rst || restart_s) begin
            acc_r        <= '0;
            cnt_r        <= '0;
            avg_r        <= '0;
            min_r        <= '1;
            max_r        <= '0;
            have_r       <= 1'b0;
            stat_valid_r <= 1'b0;
        end else if (valid_s) begin
            have_r       <= 1'b1;
            stat_valid_r <= stat_valid_r | stat_set_s;
            if (cnt_r == CNT_FULL) begin
                avg_r <= acc_sum_s[ACC_W-1:AVG_LOG2];
                acc_r <= '0;
                cnt_r <= '0;
            end else begin
                acc_r <= acc_sum_s;
                cnt_r <= cnt_r + AVG_LOG2'(1);
            end
            if (!have_r) begin
                min_r <= sample_s;
                max_r <= sample_s;
            end else begin
                if (sample_s < min_r) min_r <= sample_s;
                if (sample_s > max_r) max_r <= sample_s;
            end
        end
    end

    // Refresh divider and display latch; out-of-range keeps the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_r <= '0;
            disp_r    <= '0;
            hex_r     <= '1;
        end else begin
            ref_cnt_r <= tick_s ? '0 : ref_cnt_r + REF_W'(1);
            if (tick_s) begin
                hex_r <= hex_s;
                if (in_range_s) disp_r <= shown_s;
            end
        end
    end

    assign bus.hex_out    = hex_r;
    assign bus.disp_value = disp_r;
    assign bus.stat_valid = stat_valid_r;
endmodule

// File: tb/tb_lnvd_adc_channel_monitor.sv
// Scoreboard bench for lnvd_adc_channel_monitor: stimulus pushes expectations,
// a negedge monitor pops them against the display refresh or the current outputs.
module tb_lnvd_adc_channel_monitor;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lnvd_adc_channel_monitor_if #(.NUM_CH(4), .DATA_W(12), .NUM_DIG(3), .SEL_W(3)) bus ();

    lnvd_adc_channel_monitor #(
        .NUM_CH(4), .DATA_W(12), .NUM_DIG(3), .SEL_W(3), .AVG_LOG2(4), .REFRESH_DIV(DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind 0: next display refresh (disp+hex); 1: stat_valid now; 2: all outputs now
    typedef struct {
        int          kind;
        logic [11:0] disp;
        logic [23:0] hex;
        logic        sv;
        string       name;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Bench-side refresh model: upd marks the cycle right after a refresh edge
    int ref_cnt = 0;
    logic upd = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            ref_cnt <= 0;
            upd     <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == DIV - 1) ? 0 : ref_cnt + 1;
            upd     <= (ref_cnt == DIV - 1);
        end
    end

    // Monitor: display entries only match a refresh strictly after they were queued
    logic armed = 1'b0;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q[0];
            if (e.kind == 0) begin
                if (armed && upd) begin
                    n_checks++;
                    if (bus.disp_value === e.disp && bus.hex_out === e.hex) n_pass++;
                    else $display("FAIL %s: disp=%h hex=%h, expected disp=%h hex=%h",
                                  e.name, bus.disp_value, bus.hex_out, e.disp, e.hex);
                    void'(q.pop_front());
                    armed = 1'b0;
                end else begin
                    armed = 1'b1;
                end
            end else begin
                n_checks++;
                if (e.kind == 1) begin
                    if (bus.stat_valid === e.sv) n_pass++;
                    else $display("FAIL %s: stat_valid=%b, expected %b", e.name, bus.stat_valid, e.sv);
                end else begin
                    if (bus.stat_valid === e.sv && bus.disp_value === e.disp && bus.hex_out === e.hex) n_pass++;
                    else $display("FAIL %s: disp=%h hex=%h stat=%b, expected disp=%h hex=%h stat=%b",
                                  e.name, bus.disp_value, bus.hex_out, bus.stat_valid, e.disp, e.hex, e.sv);
                end
                void'(q.pop_front());
                armed = 1'b0;
            end
        end
    end

    task automatic push(input int kind, input logic [11:0] disp, input logic [23:0] hex,
                        input logic sv, input string name);
        exp_t e;
        e.kind = kind; e.disp = disp; e.hex = hex; e.sv = sv; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ch, input logic [11:0] v);
        bus.data_in[ch*12 +: 12] = v;
        bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DIV; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL timeout: %0d expectations left, expected 0 (first %s)", q.size(), q[0].name);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.data_in = '0; bus.sample_valid = 1'b0; bus.ch_sel = 3'd0; bus.mode = 2'd0; bus.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push(2, 12'h000, 24'hFFFFFF, 1'b0, "reset_state");
        push(0, 12'h000, 24'hC0C040, 1'b0, "first_tick_zero");
        drain();

        // live view of channel 2
        bus.ch_sel = 3'd2; bus.mode = 2'd0;
        step();
        strobe(2, 12'hA5C);
        push(1, 12'h000, 24'h0, 1'b1, "live_stat");
        push(0, 12'hA5C, 24'h8892C6, 1'b0, "live_A5C");
        drain();

        // average of 100..115 on channel 0
        bus.ch_sel = 3'd0; bus.mode = 2'd1;
        step();
        for (int i = 0; i < 16; i++) begin
            strobe(0, 12'(100 + i));
            if (i == 14) push(1, 12'h000, 24'h0, 1'b0, "avg_stat_15th");
            if (i == 15) push(1, 12'h000, 24'h0, 1'b1, "avg_stat_16th");
        end
        push(0, 12'h06B, 24'hC08283, 1'b0, "avg_06B");
        drain();

        // max hold, then switch to min hold
        bus.ch_sel = 3'd1; bus.mode = 2'd3;
        step();
        strobe(1, 12'h200);
        push(1, 12'h000, 24'h0, 1'b1, "max_stat_first");
        strobe(1, 12'h7FF);
        strobe(1, 12'h100);
        push(0, 12'h7FF, 24'hF88E8E, 1'b0, "max_7FF");
        drain();
        bus.mode = 2'd2;
        step();
        push(1, 12'h000, 24'h0, 1'b0, "mode_change_restart");
        strobe(1, 12'h300);
        push(0, 12'h300, 24'hB0C0C0, 1'b0, "min_300");
        drain();

        // clr together with a sample drops that sample
        bus.clr = 1'b1;
        strobe(1, 12'h020);
        bus.clr = 1'b0;
        push(1, 12'h000, 24'h0, 1'b0, "clr_drops_sample");
        strobe(1, 12'h050);
        push(1, 12'h000, 24'h0, 1'b1, "min_stat_after_clr");
        push(0, 12'h050, 24'hC092C0, 1'b0, "min_050");
        drain();

        // out-of-range channel shows dashes, keeps disp_value
        bus.ch_sel = 3'd5;
        step();
        push(0, 12'h050, 24'hBFBFBF, 1'b0, "out_of_range");
        drain();

        // reset in the middle of an average discards the partial block
        bus.ch_sel = 3'd0; bus.mode = 2'd1;
        step();
        for (int i = 0; i < 7; i++) strobe(0, 12'hFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(2, 12'h000, 24'hFFFFFF, 1'b0, "mid_reset_state");
        push(0, 12'h000, 24'hC0C040, 1'b0, "mid_reset_avg0");
        drain();
        for (int i = 0; i < 16; i++) begin
            strobe(0, 12'h020);
            if (i == 8)  push(1, 12'h000, 24'h0, 1'b0, "count_cleared_9th");
            if (i == 15) push(1, 12'h000, 24'h0, 1'b1, "count_cleared_16th");
        end
        push(0, 12'h020, 24'hC0A4C0, 1'b0, "avg_after_reset");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
